// File: rtl/pixel_write_sink.sv
// Pixel plot sink: queues {x,y,colour} requests in a small FIFO and turns each into one
// frame-buffer write. Also performs a full-screen clear that drains the queue first.
module pixel_write_sink #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  output logic                ready,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_done,
  output logic                fb_we,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic [7:0]          drop_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = X_W + Y_W + COLOUR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

  state_t              state;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic [CNT_W-1:0]    count;
  logic [COLOUR_W-1:0] clr_colour;
  logic [ADDR_W-1:0]   clr_addr;

  logic                push;
  logic                pop;
  logic [X_W-1:0]      head_x;
  logic [Y_W-1:0]      head_y;
  logic [COLOUR_W-1:0] head_c;
  logic                in_range;
  logic [ADDR_W-1:0]   pix_addr;

  // ready looks only at registered state (plus reset), never at plot
  assign ready = resetn && (state == IDLE) && (count < CNT_W'(FIFO_DEPTH));
  assign push  = plot && ready;
  assign pop   = ((state == IDLE) || (state == DRAIN)) && (count != '0);

  assign {head_x, head_y, head_c} = mem[rptr];
  assign in_range = (32'(head_x) < 32'(H_RES)) && (32'(head_y) < 32'(V_RES));
  assign pix_addr = ADDR_W'(head_y) * ADDR_W'(H_RES) + ADDR_W'(head_x);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {x, y, colour};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      clr_colour <= '0;
      clr_addr   <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      clear_done <= 1'b0;
      drop_count <= '0;
    end else begin
      fb_we      <= 1'b0;
      clear_done <= 1'b0;

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (pop) begin
        if (in_range) begin
          fb_we   <= 1'b1;
          fb_addr <= pix_addr;
          fb_data <= head_c;
        end else if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (clear_req) begin
            clr_colour <= clear_colour;
            state      <= DRAIN;
          end
        end
        // the last popped pixel is already on the registered outputs once count reads zero
        DRAIN: begin
          if (count == '0) begin
            clr_addr <= '0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          fb_we   <= 1'b1;
          fb_addr <= clr_addr;
          fb_data <= clr_colour;
          if (clr_addr == LAST_ADDR) state <= DONE;
          else                       clr_addr <= clr_addr + 1'b1;
        end
        DONE: begin
          clear_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed self-checking bench for pixel_write_sink: single-pixel latency, corner addressing,
// drop counting/saturation, clear sequencing and reset abort.
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        ready;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic [7:0]  drop_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned done_n = 0;

  logic [14:0] wa[$];
  logic [2:0]  wd[$];
  int unsigned wc[$];

  pixel_write_sink #(
    .H_RES(160), .V_RES(120), .X_W(8), .Y_W(7),
    .COLOUR_W(3), .ADDR_W(15), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
    .ready(ready), .clear_req(clear_req), .clear_colour(clear_colour),
    .clear_done(clear_done), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we) begin
      wa.push_back(fb_addr);
      wd.push_back(fb_data);
      wc.push_back(cyc);
    end
    if (clear_done) done_n <= done_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic flush_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  // called just after a negedge; leaves the caller just after the next negedge
  task automatic send(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc,
                      input bit chk_ready);
    plot = 1'b1; x = px; y = py; colour = pc;
    #1;
    if (chk_ready) check("ready_stream", ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    plot = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [14:0] exp_a [4];
  logic [2:0]  exp_d [4];
  int unsigned bad;
  bit          seen;

  initial begin
    resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
    clear_req = 1'b0; clear_colour = '0;

    // reset state
    @(negedge clk);
    check("ready_in_reset", ready, 0);
    repeat (2) @(negedge clk);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_drop", drop_count, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", ready, 1);

    // single pixel latency: accepted at edge e0, write visible in the second cycle after
    flush_log();
    plot = 1'b1; x = 8'd5; y = 7'd2; colour = 3'd3;
    @(posedge clk);
    @(negedge clk);
    plot = 1'b0;
    check("lat_c1_we", fb_we, 0);
    @(negedge clk);
    check("lat_c2_we", fb_we, 1);
    check("lat_addr", fb_addr, 325);
    check("lat_data", fb_data, 3);
    @(negedge clk);
    check("lat_c3_we", fb_we, 0);
    idle(2);

    // corners back-to-back
    flush_log();
    send(8'd0,   7'd0,   3'd1, 1'b1);
    send(8'd159, 7'd119, 3'd2, 1'b1);
    send(8'd159, 7'd0,   3'd4, 1'b1);
    idle(4);
    check("corner_count", wa.size(), 3);
    if (wa.size() == 3) begin
      check("corner0_addr", wa[0], 0);
      check("corner1_addr", wa[1], 19199);
      check("corner2_addr", wa[2], 159);
      check("corner2_data", wd[2], 4);
      check("corner_consec1", wc[1] - wc[0], 1);
      check("corner_consec2", wc[2] - wc[0], 2);
    end

    // out-of-range drops and saturation
    flush_log();
    send(8'd160, 7'd0,   3'd7, 1'b0);
    send(8'd0,   7'd120, 3'd7, 1'b0);
    send(8'd255, 7'd127, 3'd7, 1'b0);
    idle(3);
    check("oor_no_write", wa.size(), 0);
    check("drop_3", drop_count, 3);
    for (int i = 0; i < 300; i++) send(8'd200, 7'd5, 3'd1, 1'b0);
    idle(3);
    check("drop_sat", drop_count, 255);
    check("oor_no_write2", wa.size(), 0);

    // clear with pixels in flight, plus an ignored clear_req during CLEAR
    flush_log();
    exp_a[0] = 15'd0;     exp_d[0] = 3'd5;
    exp_a[1] = 15'd161;   exp_d[1] = 3'd6;
    exp_a[2] = 15'd19199; exp_d[2] = 3'd7;
    exp_a[3] = 15'd805;   exp_d[3] = 3'd1;
    send(8'd0,   7'd0,   3'd5, 1'b1);
    send(8'd1,   7'd1,   3'd6, 1'b1);
    send(8'd159, 7'd119, 3'd7, 1'b1);
    clear_req = 1'b1; clear_colour = 3'd2;
    send(8'd5,   7'd5,   3'd1, 1'b1);
    clear_req = 1'b0; clear_colour = 3'd0;
    plot = 1'b0;
    #1;
    check("ready_drop_on_clear", ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 20100 && !seen; i++) begin
      @(negedge clk);
      if (i == 500) begin
        check("ready_mid_clear", ready, 0);
        clear_req = 1'b1; clear_colour = 3'd6;
      end else begin
        clear_req = 1'b0;
      end
      if (clear_done) begin
        seen = 1'b1;
        check("ready_at_clear_done", ready, 1);
      end
    end
    check("clear_done_seen", seen, 1);
    idle(30);
    check("clear_done_once", done_n, 1);
    check("clear_write_count", wa.size(), 19204);
    if (wa.size() == 19204) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        check("clr_px_addr", wa[i], exp_a[i]);
        check("clr_px_data", wd[i], exp_d[i]);
      end
      for (int i = 0; i < 19200; i++)
        if (wa[4+i] != 15'(i) || wd[4+i] != 3'd2) bad++;
      check("clear_fill_bad", bad, 0);
      check("clear_contiguous", wc[19203] - wc[4], 19199);
    end

    // reset at clear address 1000
    flush_log();
    clear_req = 1'b1; clear_colour = 3'd5;
    @(negedge clk);
    clear_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (fb_we && fb_addr == 15'd1000) seen = 1'b1;
    end
    check("reach_addr_1000", seen, 1);
    resetn = 1'b0;
    #1;
    check("ready_forced_low", ready, 0);
    @(posedge clk);
    #1;
    check("abort_fb_we", fb_we, 0);
    check("abort_fb_addr", fb_addr, 0);
    check("abort_fb_data", fb_data, 0);
    check("abort_clear_done", clear_done, 0);
    check("abort_drop", drop_count, 0);
    @(negedge clk);
    flush_log();
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_abort", ready, 1);
    idle(30);
    check("abort_no_done", done_n, 1);
    check("abort_no_writes", wa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_write_sink.md
# pixel_write_sink

Receiving end of the drawing-FSM pixel interface (`plot`/`x`/`y`/`colour`): accepts pixel plot requests from the draw controllers, buffers them in a small FIFO, and turns each one into a single write to the 160x120 on-chip frame buffer. It also performs a full-screen clear on request. It sits between the draw-control FSMs and the frame-buffer RAM feeding VGA scan-out.

## Interface
Parameters:
- `H_RES`, 160, visible columns (local dots)
- `V_RES`, 120, visible rows
- `X_W`, 8, x coordinate width
- `Y_W`, 7, y coordinate width
- `COLOUR_W`, 3, colour width
- `ADDR_W`, 15, frame-buffer address width (must hold `H_RES*V_RES-1`)
- `FIFO_DEPTH`, 4, request FIFO entries (power of two)

Ports:
- `clk`  in  1  single clock for the whole block
- `resetn`  in  1  reset, synchronous and active-low
- `plot`  in  1  pixel request valid
- `x`  in  X_W  pixel column
- `y`  in  Y_W  pixel row
- `colour`  in  COLOUR_W  pixel colour
- `ready`  out  1  request can be accepted this cycle
- `clear_req`  in  1  one-cycle pulse requesting full-screen clear
- `clear_colour`  in  COLOUR_W  fill colour, sampled with `clear_req`
- `clear_done`  out  1  one-cycle pulse when clear completes
- `fb_we`  out  1  frame-buffer write enable
- `fb_addr`  out  ADDR_W  frame-buffer write address
- `fb_data`  out  COLOUR_W  frame-buffer write data
- `drop_count`  out  8  saturating count of discarded out-of-range requests

## Operation
- Handshake: a request is accepted on a rising edge where `plot && ready`. `plot` without `ready` is ignored. No retry: the sender holds its request until it is accepted.
- `ready` = (FIFO occupancy < `FIFO_DEPTH`) and state is IDLE. `ready` is combinational from registered state only; it never depends on `plot`.
- FIFO: stores {x, y, colour}. Push and pop in the same cycle are allowed when not full. Occupancy never exceeds `FIFO_DEPTH`.
- Write stage: when the FIFO is non-empty, one entry is popped per cycle.
  - In range (`x < H_RES` and `y < V_RES`): register `fb_addr = y*H_RES + x` (for 160: `(y<<7)+(y<<5)+x`, computed at `ADDR_W` bits, no truncation), `fb_data = colour`, `fb_we = 1` for one cycle.
  - Out of range: the entry is popped, `fb_we` stays 0, and `drop_count` increments, saturating at 255.
- State machine:
  - IDLE: serve FIFO. `clear_req` latches `clear_colour` and moves to DRAIN.
  - DRAIN: `ready` = 0. Keep popping until the FIFO is empty and no write is pending, then go to CLEAR with the address counter at 0.
  - CLEAR: `fb_we` = 1, `fb_data` = latched colour, `fb_addr` = counter, counter +1 per cycle. After writing address `H_RES*V_RES-1` (19199), go to DONE.
  - DONE: `clear_done` = 1 for one cycle, then IDLE.
- `clear_req` outside IDLE is ignored (no queueing). If `clear_req` and an accepted `plot` occur on the same edge, the pixel is enqueued and written before the clear starts.

## Timing
- Reset (resetn low at an edge): FIFO emptied, state IDLE, `fb_we`=0, `fb_addr`=0, `fb_data`=0, `clear_done`=0, `drop_count`=0, clear counter 0. `ready` is forced 0 while `resetn` is low and is 1 in the first cycle after release.
- Reset mid-clear or mid-drain: aborts immediately. No `clear_done` is issued, and queued pixels are lost.
- Latency: a `plot` accepted at the end of cycle c with the FIFO empty gives `fb_we` high in cycle c+2.
- Throughput: 1 pixel per cycle sustained. With `plot` held high and a constant stream, `ready` never drops.
- Clear duration: DRAIN (0..FIFO_DEPTH+1 cycles) + 19200 CLEAR cycles + 1 DONE cycle.
- `fb_we` is high for exactly one cycle per in-range pixel. Writes are in acceptance order.

## Test plan
- Reset release, then `plot` (x=5, y=2, colour=3) for one cycle → 2 cycles later `fb_we`=1, `fb_addr`=325, `fb_data`=3, for exactly one cycle.
- Corner pixels (0,0), (159,119), (159,0) back-to-back → three consecutive writes at addresses 0, 19199, 159, in that order.
- Out of range (160,0), (0,120), (255,127) → no `fb_we`; `drop_count`=3. Then 300 bad requests → `drop_count` holds at 255.
- Stall the pop side by asserting `clear_req` with 4 pixels queued → `ready` drops immediately; the 4 pixels are written first, then 19200 writes with the latched colour, then a `clear_done` pulse, then `ready`=1.
- `clear_req` during CLEAR → ignored: exactly one `clear_done`, 19200 clear writes.
- Assert `resetn`=0 at clear address 1000 → all outputs are 0 next cycle, no `clear_done`, and `ready`=1 after release.
